ft600_bus_scheduler: RTL and testbench

Sequences the FT600/FT601 245-mode synchronous FIFO bus and shares its single bidirectional data path between two streams: RX (host → ASIC) and TX (ASIC → host). It drives the OE_N/RD_N/WR_N strobes and data tri-state enable, and inserts a bus-turnaround gap between directions. When both directions are pending, it alternates grants and bounds each grant to `max_burst_p` words. It sits between the top-level FT600 pins and the ASIC-side RX/TX FIFOs; the TX FIFO head is consumed with a valid/yumi handshake.

---
 rtl/ft600_bus_scheduler_if.sv | 42 ++++
 rtl/ft600_bus_scheduler.sv | 118 +++++++++++
 tb/tb_ft600_bus_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft600_bus_scheduler_if.sv
// FT600/FT601 pad and ASIC-side stream signals for the bus scheduler.
// master: the scheduler; slave: pads plus RX/TX FIFOs.
interface ft600_bus_scheduler_if #(
    parameter int data_width_p = 32
);
    localparam int be_width_lp = data_width_p / 8;

    logic                    rxf_n_i;
    logic                    txe_n_i;
    logic                    oe_n_o;
    logic                    rd_n_o;
    logic                    wr_n_o;
    logic                    siwu_n_o;
    logic [data_width_p-1:0] data_i;
    logic [be_width_lp-1:0]  be_i;
    logic [data_width_p-1:0] data_o;
    logic [be_width_lp-1:0]  be_o;
    logic                    data_oe_o;
    logic                    rx_v_o;
    logic [data_width_p-1:0] rx_data_o;
    logic [be_width_lp-1:0]  rx_be_o;
    logic                    rx_ready_i;
    logic                    tx_v_i;
    logic [data_width_p-1:0] tx_data_i;
    logic                    tx_yumi_o;

    modport master (
        input  rxf_n_i, txe_n_i, data_i, be_i,
        input  rx_ready_i, tx_v_i, tx_data_i,
        output oe_n_o, rd_n_o, wr_n_o, siwu_n_o,
        output data_o, be_o, data_oe_o,
        output rx_v_o, rx_data_o, rx_be_o, tx_yumi_o
    );

    modport slave (
        output rxf_n_i, txe_n_i, data_i, be_i,
        output rx_ready_i, tx_v_i, tx_data_i,
        input  oe_n_o, rd_n_o, wr_n_o, siwu_n_o,
        input  data_o, be_o, data_oe_o,
        input  rx_v_o, rx_data_o, rx_be_o, tx_yumi_o
    );
endinterface

// File: rtl/ft600_bus_scheduler.sv
// FT600 245-mode synchronous FIFO bus scheduler.
// Shares the data pads between RX and TX with a turnaround gap.
module ft600_bus_scheduler #(
    parameter int data_width_p = 32,
    parameter int max_burst_p  = 64
) (
    input logic                   clk_i,
    input logic                   reset_n_i,
    ft600_bus_scheduler_if.master bus
);
    localparam int be_width_lp  = data_width_p / 8;
    localparam int cnt_width_lp = $clog2(max_burst_p + 1);

    localparam logic [cnt_width_lp-1:0] cnt_max_lp =
        cnt_width_lp'(max_burst_p);
    localparam logic [cnt_width_lp-1:0] cnt_last_lp =
        cnt_width_lp'(max_burst_p - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_OE,
        RD,
        WR,
        GAP
    } state_e;

    typedef enum logic {
        DIR_RD,
        DIR_WR
    } dir_e;

    state_e                  state_r;
    dir_e                    last_dir_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    rx_v_r;
    logic [data_width_p-1:0] rx_data_r;
    logic [be_width_lp-1:0]  rx_be_r;

    logic rd_req;
    logic wr_req;
    logic capture;
    logic yumi;
    logic burst_full;
    logic rd_stop;
    logic wr_stop;

    assign rd_req  = ~bus.rxf_n_i & bus.rx_ready_i;
    assign wr_req  = bus.tx_v_i & ~bus.txe_n_i;
    assign capture = (state_r == RD) & ~bus.rxf_n_i;
    assign yumi    = (state_r == WR) & wr_req;

    // The counter saturates, so a request arriving late in a long
    // burst still sees a full count and ends the burst.
    assign burst_full = (cnt_r >= cnt_last_lp);

    assign rd_stop = bus.rxf_n_i | ~bus.rx_ready_i
                   | (capture & burst_full & wr_req);
    assign wr_stop = ~bus.tx_v_i | bus.txe_n_i
                   | (yumi & burst_full & rd_req);

    // Sequencer: arbitration, burst counting and RX capture.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            last_dir_r <= DIR_WR;
            cnt_r      <= '0;
            rx_v_r     <= 1'b0;
            rx_data_r  <= '0;
            rx_be_r    <= '0;
        end else begin
            rx_v_r <= capture;
            if (capture) begin
                rx_data_r <= bus.data_i;
                rx_be_r   <= bus.be_i;
            end
            if ((capture | yumi) & (cnt_r != cnt_max_lp)) begin
                cnt_r <= cnt_r + 1'b1;
            end
            unique case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (rd_req & (~wr_req | (last_dir_r == DIR_WR))) begin
                        state_r    <= RD_OE;
                        last_dir_r <= DIR_RD;
                    end else if (wr_req) begin
                        state_r    <= WR;
                        last_dir_r <= DIR_WR;
                    end
                end
                RD_OE: state_r <= RD;
                RD: begin
                    if (rd_stop) begin
                        state_r <= GAP;
                    end
                end
                WR: begin
                    if (wr_stop) begin
                        state_r <= GAP;
                    end
                end
                GAP: state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.oe_n_o    = ~((state_r == RD_OE) | (state_r == RD));
    assign bus.rd_n_o    = ~(state_r == RD);
    assign bus.data_oe_o = (state_r == WR);
    assign bus.wr_n_o    = ~((state_r == WR) & bus.tx_v_i);
    assign bus.siwu_n_o  = 1'b1;
    assign bus.data_o    = bus.tx_data_i;
    assign bus.be_o      = {be_width_lp{1'b1}};
    assign bus.tx_yumi_o = yumi;
    assign bus.rx_v_o    = rx_v_r;
    assign bus.rx_data_o = rx_data_r;
    assign bus.rx_be_o   = rx_be_r;
endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// Testbench for ft600_bus_scheduler with an FT host/FIFO environment
// and a grant-level reference model checked every cycle.
module tb_ft600_bus_scheduler;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXB = 4;

    typedef logic [31:0] wq_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ft600_bus_scheduler_if #(.data_width_p(DW)) bus ();

    ft600_bus_scheduler #(
        .data_width_p(DW),
        .max_burst_p (MAXB)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    // environment: host RX words {be,data}, TX source, FT TX sink
    logic [35:0] host_q[$];
    wq_t         src_q;
    wq_t         sink_q;
    wq_t         rx_got;
    bit          host_en;
    bit          src_en;
    logic        rdy;
    logic        txe;
    bit          pop_host;
    bit          pop_src;
    bit          take_sink;
    logic [31:0] take_word;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // statistics for hand-computed expectations
    int n_oe, n_rd, n_wr, n_doe, n_yumi, n_rxv, n_cap;
    int first_oe, first_rd, first_rxv, first_yumi, last_yumi;
    int cur_dir, cur_words;
    int grants[$];
    logic [5:0] lg [0:1023];
    bit prev_oe_low;
    bit prev_doe;

    // reference model: grant ownership, not FSM states
    bit          m_rd      = 0;
    bit          m_live    = 0;
    bit          m_wr      = 0;
    bit          m_gap     = 0;
    bit          m_pref_rd = 1;
    bit          m_rxv     = 0;
    int          m_words   = 0;
    logic [31:0] m_rxd     = '0;
    logic [3:0]  m_rxbe    = '0;

    function automatic void chk(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d got=%0h want=%0h",
                         nm, cyc, act, exp);
        end
    endfunction

    function automatic int qdiff(input wq_t q, input logic [31:0] base,
                                 input int n);
        int e;
        e = 0;
        if (q.size() != n) e++;
        for (int i = 0; i < q.size() && i < n; i++)
            if (q[i] !== base + 32'(i)) e++;
        return e;
    endfunction

    function automatic void drive();
        bus.rxf_n_i    = !(host_en && host_q.size() > 0);
        bus.data_i     = host_q.size() > 0 ? host_q[0][31:0] : '0;
        bus.be_i       = host_q.size() > 0 ? host_q[0][35:32] : '0;
        bus.rx_ready_i = rdy;
        bus.txe_n_i    = txe;
        bus.tx_v_i     = src_en && src_q.size() > 0;
        bus.tx_data_i  = src_q.size() > 0 ? src_q[0] : '0;
    endfunction

    function automatic void close_grant();
        if (cur_dir != 0) grants.push_back(cur_dir * 100 + cur_words);
        cur_dir = 0;
    endfunction

    function automatic void clr_stats();
        n_oe = 0; n_rd = 0; n_wr = 0; n_doe = 0;
        n_yumi = 0; n_rxv = 0; n_cap = 0;
        first_oe = -1; first_rd = -1; first_rxv = -1;
        first_yumi = -1; last_yumi = -1;
        cur_dir = 0; cur_words = 0;
        grants.delete();
        rx_got.delete();
        sink_q.delete();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_host && host_q.size() > 0) host_q.delete(0);
        if (pop_src && src_q.size() > 0) src_q.delete(0);
        if (take_sink) sink_q.push_back(take_word);
        pop_host  = 0;
        pop_src   = 0;
        take_sink = 0;
        drive();
    endtask

    task automatic wait_cnt(input int which, input int n, input string nm);
        int v;
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            v = (which == 0) ? n_cap : (which == 1) ? n_yumi : n_rxv;
            if (v >= n) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(nm, 64'(ok), 1);
    endtask

    // model update on the clock, from the inputs the bench drives
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd = 0; m_live = 0; m_wr = 0; m_gap = 0;
            m_pref_rd = 1; m_rxv = 0; m_words = 0;
            m_rxd = '0; m_rxbe = '0;
        end else begin
            bit rreq, wreq, cap, yum, stop;
            rreq = !bus.rxf_n_i && bus.rx_ready_i;
            wreq = bus.tx_v_i && !bus.txe_n_i;
            m_rxv = 0;
            if (m_gap) begin
                m_gap = 0;
            end else if (m_rd && !m_live) begin
                m_live = 1;
            end else if (m_rd) begin
                cap = !bus.rxf_n_i;
                if (cap) begin
                    m_rxv = 1;
                    m_rxd = bus.data_i;
                    m_rxbe = bus.be_i;
                    m_words++;
                end
                stop = bus.rxf_n_i || !bus.rx_ready_i
                    || (cap && m_words >= MAXB && wreq);
                if (stop) begin
                    m_rd = 0; m_live = 0; m_gap = 1;
                end
            end else if (m_wr) begin
                yum = wreq;
                if (yum) m_words++;
                stop = !bus.tx_v_i || bus.txe_n_i
                    || (yum && m_words >= MAXB && rreq);
                if (stop) begin
                    m_wr = 0; m_gap = 1;
                end
            end else begin
                m_words = 0;
                if (rreq && (m_pref_rd || !wreq)) begin
                    m_rd = 1; m_pref_rd = 0;
                end else if (wreq) begin
                    m_wr = 1; m_pref_rd = 1;
                end
            end
        end
    end

    // compare, environment handshakes and statistics
    always @(negedge clk) begin
        cyc++;
        chk("oe_n", 64'(bus.oe_n_o), 64'(!m_rd));
        chk("rd_n", 64'(bus.rd_n_o), 64'(!(m_rd && m_live)));
        chk("data_oe", 64'(bus.data_oe_o), 64'(m_wr));
        chk("wr_n", 64'(bus.wr_n_o), 64'(!(m_wr && bus.tx_v_i)));
        chk("tx_yumi", 64'(bus.tx_yumi_o),
            64'(m_wr && bus.tx_v_i && !bus.txe_n_i));
        chk("rx_v", 64'(bus.rx_v_o), 64'(m_rxv));
        chk("rx_data", 64'(bus.rx_data_o), 64'(m_rxd));
        chk("rx_be", 64'(bus.rx_be_o), 64'(m_rxbe));
        chk("siwu_n", 64'(bus.siwu_n_o), 1);
        if (bus.data_oe_o) begin
            chk("data_o", 64'(bus.data_o), 64'(src_q.size() > 0 ? src_q[0] : 32'h0));
            chk("be_o", 64'(bus.be_o), 64'hF);
        end
        chk("overlap", 64'(!bus.oe_n_o && bus.data_oe_o), 0);
        chk("turnaround", 64'((prev_oe_low && bus.data_oe_o)
                              || (prev_doe && !bus.oe_n_o)), 0);
        prev_oe_low = !bus.oe_n_o;
        prev_doe    = bus.data_oe_o;

        pop_host  = rst_n && !bus.rd_n_o && !bus.rxf_n_i;
        pop_src   = rst_n && bus.tx_yumi_o;
        take_sink = rst_n && !bus.wr_n_o && !bus.txe_n_i;
        take_word = bus.data_o;

        lg[cyc & 1023] = {bus.oe_n_o, bus.rd_n_o, bus.wr_n_o,
                          bus.data_oe_o, bus.tx_yumi_o, bus.rx_v_o};
        if (!bus.oe_n_o) begin
            n_oe++;
            if (first_oe < 0) first_oe = cyc;
        end
        if (!bus.rd_n_o) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (!bus.wr_n_o) n_wr++;
        if (bus.data_oe_o) n_doe++;
        if (bus.tx_yumi_o) begin
            n_yumi++;
            if (first_yumi < 0) first_yumi = cyc;
            last_yumi = cyc;
        end
        if (bus.rx_v_o) begin
            n_rxv++;
            if (first_rxv < 0) first_rxv = cyc;
            rx_got.push_back(bus.rx_data_o);
        end
        if (pop_host) n_cap++;

        if (!bus.oe_n_o) begin
            if (cur_dir != 1) begin
                close_grant();
                cur_dir = 1;
                cur_words = 0;
            end
            if (pop_host) cur_words++;
        end else if (bus.data_oe_o) begin
            if (cur_dir != 2) begin
                close_grant();
                cur_dir = 2;
                cur_words = 0;
            end
            if (bus.tx_yumi_o) cur_words++;
        end else begin
            close_grant();
        end
    end

    initial begin
        int c0;
        int base_cap;
        int base_yumi;
        clr_stats();
        host_en = 0; src_en = 0; rdy = 1; txe = 0;
        drive();
        step();
        step();
        chk("rst_oe_n", 64'(bus.oe_n_o), 1);
        chk("rst_rd_n", 64'(bus.rd_n_o), 1);
        chk("rst_wr_n", 64'(bus.wr_n_o), 1);
        chk("rst_data_oe", 64'(bus.data_oe_o), 0);
        chk("rst_rx_v", 64'(bus.rx_v_o), 0);
        chk("rst_yumi", 64'(bus.tx_yumi_o), 0);
        chk("rst_rx_data", 64'(bus.rx_data_o), 0);
        rst_n = 1;
        step();
        step();

        // single read of three words
        clr_stats();
        host_q = '{36'hF_000000A0, 36'h3_000000A1, 36'h1_000000A2};
        host_en = 1;
        drive();
        c0 = cyc;
        repeat (10) step();
        chk("rd_first_oe", 64'(first_oe - c0), 2);
        chk("rd_first_rd", 64'(first_rd - c0), 3);
        chk("rd_first_rxv", 64'(first_rxv - c0), 4);
        chk("rd_rxv_count", 64'(n_rxv), 3);
        chk("rd_words", 64'(qdiff(rx_got, 32'hA0, 3)), 0);
        chk("rd_oe_cycles", 64'(n_oe), 5);
        chk("rd_rd_cycles", 64'(n_rd), 4);
        chk("rd_idle_after", 64'(bus.oe_n_o), 1);

        // write burst of five words
        clr_stats();
        for (int i = 0; i < 5; i++) src_q.push_back(32'h1111_0000 + 32'(i));
        src_en = 1;
        drive();
        c0 = cyc;
        repeat (10) step();
        chk("wr_first_yumi", 64'(first_yumi - c0), 2);
        chk("wr_yumi_count", 64'(n_yumi), 5);
        chk("wr_yumi_run", 64'(last_yumi - first_yumi), 4);
        chk("wr_wr_n_cycles", 64'(n_wr), 5);
        chk("wr_data_oe_cycles", 64'(n_doe), 6);
        chk("wr_sink", 64'(qdiff(sink_q, 32'h1111_0000, 5)), 0);

        // contention, both directions continuously pending
        clr_stats();
        for (int i = 0; i < 12; i++) begin
            host_q.push_back({4'hF, 32'hB000_0000 + 32'(i)});
            src_q.push_back(32'hC000_0000 + 32'(i));
        end
        drive();
        repeat (60) step();
        chk("ct_grants", 64'(grants.size()), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("ct_grant", 64'(grants[i]), (i % 2 == 0) ? 104 : 204);
        chk("ct_rx_words", 64'(qdiff(rx_got, 32'hB000_0000, 12)), 0);
        chk("ct_tx_words", 64'(qdiff(sink_q, 32'hC000_0000, 12)), 0);

        // RX backpressure mid-read
        clr_stats();
        for (int i = 0; i < 8; i++)
            host_q.push_back({4'hF, 32'hD0 + 32'(i)});
        drive();
        wait_cnt(0, 2, "bp_wait");
        rdy = 0;
        drive();
        c0 = cyc;
        base_cap = n_cap;
        repeat (5) step();
        chk("bp_extra_caps", 64'(n_cap - base_cap), 1);
        chk("bp_rd_n_high", 64'(lg[(c0 + 2) & 1023][4]), 1);
        rdy = 1;
        drive();
        repeat (20) step();
        chk("bp_words", 64'(qdiff(rx_got, 32'hD0, 8)), 0);

        // TXE stall mid-write
        clr_stats();
        for (int i = 0; i < 6; i++) src_q.push_back(32'hE0 + 32'(i));
        drive();
        wait_cnt(1, 2, "txe_wait");
        txe = 1;
        drive();
        c0 = cyc;
        base_yumi = n_yumi;
        repeat (4) step();
        chk("txe_no_yumi", 64'(lg[(c0 + 1) & 1023][1]), 0);
        chk("txe_wr_n_high", 64'(lg[(c0 + 2) & 1023][3]), 1);
        chk("txe_yumi_hold", 64'(n_yumi - base_yumi), 0);
        txe = 0;
        drive();
        repeat (15) step();
        chk("txe_words", 64'(qdiff(sink_q, 32'hE0, 6)), 0);

        // reset in the middle of a read burst
        clr_stats();
        src_en = 0;
        for (int i = 0; i < 6; i++) begin
            host_q.push_back({4'h7, 32'hF0 + 32'(i)});
            src_q.push_back(32'h5500 + 32'(i));
        end
        drive();
        wait_cnt(2, 1, "mr_wait");
        rst_n = 0;
        #1;
        chk("mr_oe_n", 64'(bus.oe_n_o), 1);
        chk("mr_rd_n", 64'(bus.rd_n_o), 1);
        chk("mr_wr_n", 64'(bus.wr_n_o), 1);
        chk("mr_data_oe", 64'(bus.data_oe_o), 0);
        chk("mr_rx_v", 64'(bus.rx_v_o), 0);
        chk("mr_rx_data", 64'(bus.rx_data_o), 0);
        chk("mr_rx_be", 64'(bus.rx_be_o), 0);
        src_en = 1;
        drive();
        step();
        step();
        clr_stats();
        rst_n = 1;
        repeat (12) step();
        chk("mr_first_dir", 64'(grants.size() > 0 ? grants[0] / 100 : 0), 1);
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
